mem_access_stage: RTL

Memory-access pipeline stage sitting directly downstream of the operation-prep/ALU path and upstream of register writeback. Takes a completed ALU result (address or arithmetic value), the store data the prep stage routes toward the D-cache, and the memory/writeback control flags. Performs at most one outstanding data-memory transaction with a req/ack handshake and a timeout, then presents a single writeback beat with a valid/ready handshake.

---
 rtl/arm_lp_pkg.sv | 19 +
 rtl/mem_timeout_counter.sv | 31 +++
 rtl/mem_access_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/arm_lp_pkg.sv
// rtl/arm_lp_pkg.sv - shared types and constants for the memory-access stage
package arm_lp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [4:0] XZR_REG            = 5'd31;
    localparam int         DEFAULT_DATA_WIDTH = 32;
    localparam int         TIMEOUT_WIDTH      = 8;

    // Register 31 is the zero register: a write to it is always dropped.
    function automatic logic wb_enable(input logic reg_write, input logic [4:0] dest);
        return reg_write && (dest != XZR_REG);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - cycle counter flagging a memory transaction that never acks
module mem_timeout_counter
    import arm_lp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [TIMEOUT_WIDTH-1:0] count;

    // Count waiting cycles; clear wins so a fresh transaction always starts at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // done marks the edge at which the count reaches TIMEOUT_CYCLES, so the
    // owner can abort on that same edge rather than one cycle later.
    assign done = enable && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with one outstanding transaction
module mem_access_stage
    import arm_lp_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] aluResult,
    input  logic [DATA_WIDTH-1:0] storeData,
    input  logic                  memReadFlag,
    input  logic                  memWriteFlag,
    input  logic                  regWrite,
    input  logic [4:0]            writeRegister,
    output logic                  memReq,
    output logic                  memWe,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic                  wbValid,
    input  logic                  wbReady,
    output logic                  wbRegWrite,
    output logic [4:0]            wbWriteRegister,
    output logic [DATA_WIDTH-1:0] wbWriteData,
    output logic                  memError
);

    state_t state;
    state_t next_state;

    logic accept;
    logic mem_op;
    logic misaligned;
    logic start_access;
    logic timeout_done;
    logic pend_store;
    logic pend_rw;

    assign inReady      = (state == IDLE) || ((state == HOLD) && wbReady);
    assign accept       = inValid && inReady;
    assign mem_op       = memReadFlag || memWriteFlag;
    assign misaligned   = (aluResult[1:0] != 2'b00);
    assign start_access = accept && mem_op && !misaligned;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (start_access),
        .enable ((state == ACCESS) && !memAck),
        .done   (timeout_done)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a misaligned mem op skips ACCESS and reports straight to HOLD.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (inValid) begin
                    next_state = (mem_op && !misaligned) ? ACCESS : HOLD;
                end
            end
            ACCESS: begin
                if (memAck || timeout_done) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (wbReady) begin
                    if (inValid) begin
                        next_state = (mem_op && !misaligned) ? ACCESS : HOLD;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs: request side, writeback beat, sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            memReq          <= 1'b0;
            memWe           <= 1'b0;
            memAddr         <= '0;
            memWData        <= '0;
            wbValid         <= 1'b0;
            wbRegWrite      <= 1'b0;
            wbWriteRegister <= 5'd0;
            wbWriteData     <= '0;
            memError        <= 1'b0;
            pend_store      <= 1'b0;
            pend_rw         <= 1'b0;
        end else begin
            case (state)
                ACCESS: begin
                    // Ack is checked first so it beats a timeout on the same edge.
                    if (memAck) begin
                        memReq  <= 1'b0;
                        memWe   <= 1'b0;
                        wbValid <= 1'b1;
                        if (pend_store) begin
                            wbWriteData <= '0;
                            wbRegWrite  <= 1'b0;
                        end else begin
                            wbWriteData <= memRData;
                            wbRegWrite  <= pend_rw;
                        end
                    end else if (timeout_done) begin
                        memReq      <= 1'b0;
                        memWe       <= 1'b0;
                        memError    <= 1'b1;
                        wbValid     <= 1'b1;
                        wbRegWrite  <= 1'b0;
                        wbWriteData <= '0;
                    end
                end
                HOLD: begin
                    if (wbReady && !inValid) begin
                        wbValid <= 1'b0;
                    end
                end
                default: ;
            endcase

            // A new beat only arrives in IDLE or HOLD, never while ACCESS is active.
            if (accept) begin
                wbWriteRegister <= writeRegister;
                if (!mem_op) begin
                    wbValid     <= 1'b1;
                    wbWriteData <= aluResult;
                    wbRegWrite  <= wb_enable(regWrite, writeRegister);
                end else if (misaligned) begin
                    memError    <= 1'b1;
                    wbValid     <= 1'b1;
                    wbWriteData <= '0;
                    wbRegWrite  <= 1'b0;
                end else begin
                    wbValid    <= 1'b0;
                    memReq     <= 1'b1;
                    memWe      <= memWriteFlag;
                    memAddr    <= aluResult;
                    memWData   <= storeData;
                    pend_store <= memWriteFlag;
                    pend_rw    <= wb_enable(regWrite, writeRegister);
                end
            end
        end
    end

endmodule
